// File: rtl/nwc_pkg.sv
// Shared definitions for the NWC coefficient loader: default sizes, FSM states
// and a counter-width helper.
package nwc_pkg;

  localparam int unsigned NWC_COEFF_W = 30;
  localparam int unsigned NWC_N_WORDS = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_RES,
    ST_DRAIN
  } nwc_state_e;

  // Word counter width; at least one bit so degenerate sizes still elaborate.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nwc_loader.sv
// Packs pairs of streamed coefficients into two-coefficient words for the NWC
// processor, launches it and waits for its result stream to finish.
module nwc_loader
  import nwc_pkg::*;
#(
  parameter int unsigned COEFF_W = NWC_COEFF_W,
  parameter int unsigned N_WORDS = NWC_N_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [COEFF_W-1:0]   s_coe0,
  input  logic [COEFF_W-1:0]   s_coe1,
  output logic [2*COEFF_W-1:0] data_in0,
  output logic [2*COEFF_W-1:0] data_in1,
  output logic                 write_enable,
  output logic                 start,
  input  logic                 output_active,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W  = cnt_width(N_WORDS);
  localparam int unsigned WORD_W = 2 * COEFF_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

  nwc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               half_q, half_d;
  logic [COEFF_W-1:0] hold0_q, hold0_d;
  logic [COEFF_W-1:0] hold1_q, hold1_d;
  logic [WORD_W-1:0]  data0_q, data0_d;
  logic [WORD_W-1:0]  data1_q, data1_d;
  logic               s_ready_q, s_ready_d;
  logic               we_q, we_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               beat_c;

  assign beat_c = s_valid && s_ready_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    half_d     = half_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    we_d       = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (beat_c) begin
          state_d = ST_LOAD;
          if (!half_q) begin
            hold0_d = s_coe0;
            hold1_d = s_coe1;
            half_d  = 1'b1;
          end else begin
            // Odd beat completes a word: odd coefficient in the upper half.
            data0_d = {s_coe0, hold0_q};
            data1_d = {s_coe1, hold1_q};
            we_d    = 1'b1;
            half_d  = 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              state_d    = ST_START;
            end else begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (output_active) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!output_active) begin
          done_d     = 1'b1;
          word_cnt_d = '0;
          half_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      half_q     <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      half_q     <= half_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      s_ready_q  <= s_ready_d;
      we_q       <= we_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign data_in0     = data0_q;
  assign data_in1     = data1_q;
  assign write_enable = we_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
